// File: rtl/module_serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding and
// slice-counter sizing.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Counter only has to reach NUM_DIGITS-1; keep at least one bit so the
    // single-slice configuration still has a legal vector.
    function automatic int cnt_width(input int num_digits);
        if (num_digits > 1) begin
            return $clog2(num_digits);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/module_serial_subtractor_if.sv
// Request/result bundle of the serial subtractor. The master side issues
// operands and start; the slave side (the subtractor) returns status and results.
interface module_serial_subtractor_if #(
    parameter int SUBWIDE = 64
);
    logic               start_i;
    logic [SUBWIDE-1:0] a_i;
    logic [SUBWIDE-1:0] b_i;
    logic               borrow_i;
    logic               busy_o;
    logic               done_o;
    logic [SUBWIDE-1:0] diff_o;
    logic               borrow_o;
    logic               overflow_o;

    modport master (
        output start_i, a_i, b_i, borrow_i,
        input  busy_o, done_o, diff_o, borrow_o, overflow_o
    );

    modport slave (
        input  start_i, a_i, b_i, borrow_i,
        output busy_o, done_o, diff_o, borrow_o, overflow_o
    );
endinterface

// File: rtl/module_serial_subtractor_digit.sv
// Combinational DIGIT-bit ripple-borrow slice: a - b - borrow computed as
// a + ~b + ~borrow, with the borrow-out being the inverted carry-out.
module module_digit_subtractor #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             borrow_i,
    output logic [DIGIT-1:0] diff_o,
    output logic             borrow_o,
    output logic             msb_carry_o
);
    logic [DIGIT:0]   w_sum;
    logic [DIGIT-1:0] w_b_inv;

    assign w_b_inv  = ~b_i;
    assign w_sum    = {1'b0, a_i} + {1'b0, w_b_inv} + {{DIGIT{1'b0}}, ~borrow_i};
    assign diff_o   = w_sum[DIGIT-1:0];
    assign borrow_o = ~w_sum[DIGIT];

    // The carry entering the MSB is recovered from the MSB sum bit and its addends.
    assign msb_carry_o = w_sum[DIGIT-1] ^ a_i[DIGIT-1] ^ w_b_inv[DIGIT-1];

endmodule

// File: rtl/module_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_i, one DIGIT-bit slice per clock,
// LSB slice first. Define SUB_OVERFLOW_EN to enable signed-overflow reporting.
module module_serial_subtractor
    import sub_pkg::*;
#(
    parameter int SUBWIDE = 64,
    parameter int DIGIT   = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    module_serial_subtractor_if.slave   sub_if
);
    localparam int NUM_DIGITS = SUBWIDE / DIGIT;
    localparam int CNT_W      = cnt_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    sub_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SUBWIDE-1:0] r_a;
    logic [SUBWIDE-1:0] r_b;
    logic [SUBWIDE-1:0] r_diff;
    logic               r_borrow;
    logic               r_busy;
    logic               r_done;
    logic               r_borrow_out;

    logic [DIGIT-1:0]         w_slice_diff;
    logic                     w_slice_borrow;
    logic                     w_msb_carry;
    logic                     w_last;
    logic [SUBWIDE+DIGIT-1:0] w_diff_cat;
    logic [SUBWIDE-1:0]       w_diff_next;

    module_digit_subtractor #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i         (r_a[DIGIT-1:0]),
        .b_i         (r_b[DIGIT-1:0]),
        .borrow_i    (r_borrow),
        .diff_o      (w_slice_diff),
        .borrow_o    (w_slice_borrow),
        .msb_carry_o (w_msb_carry)
    );

    // New slice enters at the top of the result; after NUM_DIGITS shifts the
    // first slice has arrived at the bottom. Also covers DIGIT == SUBWIDE.
    assign w_diff_cat  = {w_slice_diff, r_diff} >> DIGIT;
    assign w_diff_next = w_diff_cat[SUBWIDE-1:0];
    assign w_last      = (r_cnt == LAST_CNT);

`ifdef SUB_OVERFLOW_EN
    logic r_overflow;

    // Signed overflow captured from the final slice only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_overflow <= w_msb_carry ^ ~w_slice_borrow;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign sub_if.overflow_o = r_overflow;
`else
    logic w_unused_msb_carry;
    assign w_unused_msb_carry = w_msb_carry;
    assign sub_if.overflow_o  = 1'b0;
`endif

    // FSM, slice counter, operand/result shift registers and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_borrow_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (sub_if.start_i) begin
                        r_a      <= sub_if.a_i;
                        r_b      <= sub_if.b_i;
                        r_borrow <= sub_if.borrow_i;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                RUN: begin
                    r_diff   <= w_diff_next;
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_borrow <= w_slice_borrow;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_borrow_out <= w_slice_borrow;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_busy       <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sub_if.busy_o   = r_busy;
    assign sub_if.done_o   = r_done;
    assign sub_if.diff_o   = r_diff;
    assign sub_if.borrow_o = r_borrow_out;

endmodule

// File: tb/tb_module_serial_subtractor.sv
// Self-checking bench for module_serial_subtractor (SUBWIDE=8, DIGIT=4) against
// an arithmetic reference model; honours SUB_OVERFLOW_EN like the design.
module tb_module_serial_subtractor;
    localparam int SW = 8;
    localparam int DG = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    module_serial_subtractor_if #(.SUBWIDE(SW)) sub_if ();

    module_serial_subtractor #(
        .SUBWIDE (SW),
        .DIGIT   (DG)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .sub_if (sub_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, borrow, diff} from plain integer arithmetic.
    function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int   ud;
        int   sd;
        logic ovf;
        logic [7:0] d;
        ud  = int'(a) - int'(b) - int'(bin);
        sd  = int'($signed(a)) - int'($signed(b)) - int'(bin);
        d   = 8'(ud);
`ifdef SUB_OVERFLOW_EN
        ovf = (sd > 127) || (sd < -128);
`else
        ovf = 1'b0;
`endif
        return {ovf, (ud < 0), d};
    endfunction

    task automatic check_result(input string tag, input logic [9:0] exp);
        check({tag, "_diff"},   32'(sub_if.diff_o),     32'(exp[7:0]));
        check({tag, "_borrow"}, 32'(sub_if.borrow_o),   32'(exp[8]));
        check({tag, "_ovf"},    32'(sub_if.overflow_o), 32'(exp[9]));
    endtask

    // One full operation with fixed-latency checks; optionally disturbs the
    // inputs and pulses start during RUN and DONE.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input bit disturb);
        logic [9:0] exp;
        exp = ref_sub(a, b, bin);
        @(negedge clk);
        sub_if.start_i = 1'b1; sub_if.a_i = a; sub_if.b_i = b; sub_if.borrow_i = bin;
        @(negedge clk);
        sub_if.start_i = 1'b0;
        check({tag, "_busy1"}, 32'(sub_if.busy_o), 32'd1);
        check({tag, "_done1"}, 32'(sub_if.done_o), 32'd0);
        if (disturb) begin
            sub_if.start_i = 1'b1; sub_if.a_i = 8'hFF; sub_if.b_i = 8'hFF; sub_if.borrow_i = ~bin;
        end
        @(negedge clk);
        check({tag, "_busy2"}, 32'(sub_if.busy_o), 32'd1);
        check({tag, "_done2"}, 32'(sub_if.done_o), 32'd0);
        sub_if.start_i = disturb;
        @(negedge clk);
        sub_if.start_i = 1'b0;
        check({tag, "_busy3"}, 32'(sub_if.busy_o), 32'd0);
        check({tag, "_done3"}, 32'(sub_if.done_o), 32'd1);
        check_result(tag, exp);
        @(negedge clk);
        check({tag, "_busy4"}, 32'(sub_if.busy_o), 32'd0);
        check({tag, "_done4"}, 32'(sub_if.done_o), 32'd0);
    endtask

    initial begin
        logic [9:0] q[$];
        logic [9:0] exp;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        sub_if.start_i = 1'b0; sub_if.a_i = 8'h00; sub_if.b_i = 8'h00; sub_if.borrow_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(sub_if.busy_o), 32'd0);
        check("rst_done", 32'(sub_if.done_o), 32'd0);
        check_result("rst", 10'h000);
        rst = 1'b0;

        do_op("basic",   8'h0A, 8'h05, 1'b0, 1'b0);
        check_result("basic_hold", ref_sub(8'h0A, 8'h05, 1'b0));
        do_op("uborrow", 8'h05, 8'h0A, 1'b0, 1'b0);
        do_op("zero_b1", 8'h00, 8'h00, 1'b1, 1'b0);
        do_op("sovf",    8'h80, 8'h01, 1'b0, 1'b0);
        do_op("busy",    8'h10, 8'h01, 1'b0, 1'b1);

        // Reset on the first RUN edge aborts the operation.
        @(negedge clk);
        sub_if.start_i = 1'b1; sub_if.a_i = 8'h80; sub_if.b_i = 8'h01; sub_if.borrow_i = 1'b1;
        @(negedge clk);
        sub_if.start_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(sub_if.busy_o), 32'd0);
        check("abort_done", 32'(sub_if.done_o), 32'd0);
        check_result("abort", 10'h000);
        @(negedge clk);
        check("abort_nodone", 32'(sub_if.done_o), 32'd0);
        do_op("after_abort", 8'h33, 8'h44, 1'b1, 1'b0);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1; sub_if.start_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; sub_if.start_i = 1'b0;
        check("rst_vs_start_busy", 32'(sub_if.busy_o), 32'd0);
        @(negedge clk);
        check("rst_vs_start_busy2", 32'(sub_if.busy_o), 32'd0);

        for (int k = 0; k < 12; k++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            do_op("rand", ra, rb, rbin, bit'($urandom_range(0, 1)));
        end

        // Start held high: accept every 4 cycles, operands change every cycle.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("b2b_done", 32'(sub_if.done_o), 32'((i % 4) == 3));
            if (sub_if.done_o) begin
                if (q.size() == 0) begin
                    check("b2b_queue_empty", 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    check_result("b2b", exp);
                end
            end
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            sub_if.start_i = 1'b1; sub_if.a_i = ra; sub_if.b_i = rb; sub_if.borrow_i = rbin;
            if ((i % 4) == 0) begin
                q.push_back(ref_sub(ra, rb, rbin));
            end
        end
        @(negedge clk);
        sub_if.start_i = 1'b0;
        check("b2b_drained", 32'(q.size()), 32'd0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/module_serial_subtractor.md
# module_serial_subtractor

Multi-cycle two's-complement subtractor that computes `a_i - b_i - borrow_i` one `DIGIT`-bit slice per clock, least significant slice first. The borrow ripples between slices through a register. It is the complementary datapath to the team's ripple-carry adders: where a full-width adder is too large or too slow, this block trades latency for area. It is started with a single-cycle request, reports completion with a one-cycle `done_o` pulse, and holds its result until the next accepted start.

## Interface
- `SUBWIDE`, default 64: operand and result width; must be a multiple of `DIGIT`.
- `DIGIT`, default 8: bits processed per cycle; `NUM_DIGITS = SUBWIDE/DIGIT`.

- `clk_i` input, 1: single clock; everything is rising-edge.
- `rst_i` input, 1: reset, synchronous and active-high.
- `start_i` input, 1: request; accepted only in IDLE.
- `a_i` input, SUBWIDE: minuend; sampled on the accept edge.
- `b_i` input, SUBWIDE: subtrahend; sampled on the accept edge.
- `borrow_i` input, 1: borrow-in; sampled on the accept edge.
- `busy_o` output, 1: high while in RUN.
- `done_o` output, 1: one-cycle completion pulse.
- `diff_o` output, SUBWIDE: result `a - b - borrow_i` modulo 2^SUBWIDE.
- `borrow_o` output, 1: unsigned borrow-out, 1 when `a < b + borrow_i`.
- `overflow_o` output, 1: signed overflow; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start_i=1`.
  - RUN -> DONE when the slice counter reaches `NUM_DIGITS-1`.
  - DONE -> IDLE unconditionally.
- On the accept edge the block:
  - latches `a_i` and `b_i` into shift registers;
  - loads the borrow register with `borrow_i`;
  - clears the slice counter.
- Inputs are not required to be stable after the accept edge.
- Each RUN edge:
  - subtracts the low `DIGIT` bits of `a` and `b` with the registered borrow;
  - shifts the result slice into `diff_o` from the MSB end, so the first slice ends up at bits [DIGIT-1:0] after `NUM_DIGITS` shifts;
  - shifts the operands right by `DIGIT`;
  - updates the borrow register;
  - increments the counter.
- Slice arithmetic is `a + ~b + ~borrow` with carry-in `~borrow`; the slice borrow-out is the inverted carry-out.
- `borrow_o` takes the final slice borrow on the last RUN edge.
- `start_i` in RUN or DONE is ignored; nothing is queued.
- `diff_o`, `borrow_o` and `overflow_o` hold their value in IDLE until the next accept. They are not valid while `busy_o=1`.
- `DIGIT == SUBWIDE` is legal: RUN lasts exactly one cycle.

## Timing
- Reset: state IDLE, counter 0, and `busy_o`, `done_o`, `diff_o`, `borrow_o`, `overflow_o` all 0.
- Reset in any state (including mid-RUN) aborts the operation on that edge. No `done_o` is produced for the aborted request.
- Accept at edge T0:
  - `busy_o=1` from T0 through edge T(NUM_DIGITS);
  - `done_o=1` for exactly the one cycle after edge T(NUM_DIGITS), with the final results already valid in that cycle;
  - at edge T(NUM_DIGITS+1) the state returns to IDLE, and a new start can be accepted from that edge onward.
- Throughput is one operation per `NUM_DIGITS+2` cycles.
- `start_i` and `rst_i` on the same edge: reset wins.

## Configuration
- `SUB_OVERFLOW_EN` defined:
  - on the last RUN edge, `overflow_o = carry_into_msb XOR carry_out_of_msb` of the final slice;
  - this equals 1 when `a` and `b` have different signs and the result's sign differs from `a`'s.
- Not defined: `overflow_o` is tied to 0 and no overflow logic is synthesised. The port list does not change.

## Structure
- Package `sub_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t`;
  - helper `function` computing counter width `$clog2(NUM_DIGITS)` (minimum 1).
- Sub-module `module_digit_subtractor #(DIGIT)`:
  - combinational DIGIT-bit ripple-borrow slice;
  - ports `a_i`, `b_i`, `borrow_i`, `diff_o`, `borrow_o`, `msb_carry_o` (carry into the MSB, for overflow).
- The top level holds the FSM, counter, shift registers and output registers only.

## Test plan
All scenarios use `SUBWIDE=8`, `DIGIT=4` (NUM_DIGITS=2).
- Basic subtract: a=0x0A, b=0x05, borrow_i=0 -> `done_o` on the 3rd cycle after accept; `diff_o=0x05`, `borrow_o=0`, `overflow_o=0`.
- Unsigned borrow: a=0x05, b=0x0A -> `diff_o=0xFB`, `borrow_o=1`. With the macro defined: a=0x00, b=0x00, borrow_i=1 -> `diff_o=0xFF`, `borrow_o=1`, `overflow_o=0`.
- Signed overflow, macro defined: a=0x80, b=0x01 -> `diff_o=0x7F`, `overflow_o=1`, `borrow_o=0`. Macro undefined: same case gives `overflow_o=0`.
- Start while busy: accept a=0x10, b=0x01; pulse `start_i` with a=0xFF, b=0xFF during RUN and during DONE -> exactly one `done_o` with `diff_o=0x0F`; inputs changed after accept do not affect the result.
- Reset mid-op: accept, assert `rst_i` on the first RUN edge -> all outputs 0 on the next cycle, no `done_o`; a new start 1 cycle later completes normally.
- Back-to-back: start held high continuously -> accepts on every IDLE cycle, `done_o` every 4 cycles, each result correct (randomised operands checked against the reference model `a-b-borrow_i`).
